maxpool_stream: RTL and testbench

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

---
 rtl/maxpool_stream.sv | 140 ++++++++++++++
 tb/tb_maxpool_stream.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming max/min pooling over windows of up to WIN samples.
// A window closes on its WIN-th accepted sample or on any accepted sample
// with in_last set. Each closed window produces one registered result that
// holds the pooled value, the in-window position of the first winning sample,
// and the number of samples in the window.
module maxpool_stream #(
  parameter int DATA_W = 8,
  parameter int WIN    = 4,
  parameter int SIGNED = 0,
  parameter int MODE   = 0,
  localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1,
  localparam int CNT_W = $clog2(WIN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic [CNT_W-1:0]  out_count
);

  // Window length expressed in the counter's own width.
  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN);

  // Flipping the sign bit maps two's complement ordering onto unsigned
  // ordering, so one full-width magnitude compare serves both encodings.
  localparam logic [DATA_W-1:0] BIAS =
    (SIGNED != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] acc, acc_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              accept;
  logic              close;
  logic              wins;
  logic [DATA_W-1:0] key_in;
  logic [DATA_W-1:0] key_acc;

  // Upstream is stalled only while a result is held and not being taken.
  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  // Strict comparison: ties leave the earlier sample as the winner.
  always_comb begin
    key_in  = in_data ^ BIAS;
    key_acc = acc ^ BIAS;
    if (MODE != 0) begin
      wins = (key_in < key_acc);
    end else begin
      wins = (key_in > key_acc);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: any accepted sample leaves EMPTY; a closing sample returns to it.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (close) begin
        state_nxt = EMPTY;
      end else begin
        state_nxt = ACCUM;
      end
    end
  end

  // Accumulator update and window-close decision for the current sample.
  always_comb begin
    acc_nxt = acc;
    idx_nxt = idx;
    cnt_nxt = cnt;
    close   = 1'b0;
    if (accept) begin
      if (state == EMPTY) begin
        acc_nxt = in_data;
        idx_nxt = '0;
        cnt_nxt = CNT_W'(1);
      end else begin
        if (wins) begin
          acc_nxt = in_data;
          idx_nxt = cnt[IDX_W-1:0];
        end
        cnt_nxt = cnt + CNT_W'(1);
      end
      close = in_last || (cnt_nxt == WIN_CNT);
    end
  end

  // Accumulator registers; a closed window leaves the counter at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_nxt;
      idx <= idx_nxt;
      cnt <= close ? '0 : cnt_nxt;
    end
  end

  // Result register: loads on close, otherwise clears once taken downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_count <= '0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_data  <= acc_nxt;
      out_idx   <= idx_nxt;
      out_count <= cnt_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream: four instances cover unsigned max,
// signed max, unsigned min and single-sample windows.
module tb_maxpool_stream;

  logic clk;
  logic rst_n;

  logic       iv   [4];
  logic       il   [4];
  logic       ordy [4];
  logic       irdy [4];
  logic       ov   [4];
  logic [7:0] id   [4];
  logic [7:0] od   [4];

  logic [1:0] oidx0, oidx1, oidx2;
  logic       oidx3;
  logic [2:0] ocnt0, ocnt1, ocnt2;
  logic       ocnt3;

  logic [31:0] oi32 [4];
  logic [31:0] oc32 [4];

  assign oi32[0] = 32'(oidx0);
  assign oi32[1] = 32'(oidx1);
  assign oi32[2] = 32'(oidx2);
  assign oi32[3] = 32'(oidx3);
  assign oc32[0] = 32'(ocnt0);
  assign oc32[1] = 32'(ocnt1);
  assign oc32[2] = 32'(ocnt2);
  assign oc32[3] = 32'(ocnt3);

  typedef struct {
    int         dut;
    logic [7:0] data;
    int         idx;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  maxpool_stream #(.DATA_W(8), .WIN(4), .SIGNED(0), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_data(id[0]), .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .out_idx(oidx0), .out_count(ocnt0));

  maxpool_stream #(.DATA_W(8), .WIN(4), .SIGNED(1), .MODE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_data(id[1]), .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_idx(oidx1), .out_count(ocnt1));

  maxpool_stream #(.DATA_W(8), .WIN(4), .SIGNED(0), .MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_data(id[2]), .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od[2]), .out_idx(oidx2), .out_count(ocnt2));

  maxpool_stream #(.DATA_W(8), .WIN(1), .SIGNED(0), .MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(irdy[3]),
    .in_data(id[3]), .in_last(il[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
    .out_data(od[3]), .out_idx(oidx3), .out_count(ocnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every transfer pops the oldest expectation and compares it.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && ordy[k]) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: dut%0d data=%0d idx=%0d cnt=%0d, none expected",
                     k, od[k], oi32[k], oc32[k]);
          end else begin
            mon_e = sb.pop_front();
            chk("out_dut", 32'(k), 32'(mon_e.dut));
            chk("out_data", 32'(od[k]), 32'(mon_e.data));
            chk("out_idx", oi32[k], 32'(mon_e.idx));
            chk("out_count", oc32[k], 32'(mon_e.cnt));
          end
        end
      end
    end
  end

  // Presents one sample and waits, bounded, until it is accepted.
  task automatic send(input int k, input logic [7:0] d, input logic last);
    bit took;
    int guard;
    iv[k] = 1'b1;
    id[k] = d;
    il[k] = last;
    took  = 1'b0;
    guard = 0;
    while (!took && guard < 100) begin
      @(negedge clk);
      took = irdy[k];
      @(posedge clk);
      guard++;
    end
    if (!took) chk("accept_timeout", 32'(0), 32'(1));
    #1;
  endtask

  task automatic idle(input int k, input int cycles);
    iv[k] = 1'b0;
    il[k] = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input int k, input logic [7:0] d, input int ix, input int c);
    exp_t e;
    e.dut  = k;
    e.data = d;
    e.idx  = ix;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      iv[k]   = 1'b0;
      il[k]   = 1'b0;
      id[k]   = '0;
      ordy[k] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov[0]), 0);
    chk("rst_out_data", 32'(od[0]), 0);
    chk("rst_out_idx", oi32[0], 0);
    chk("rst_out_count", oc32[0], 0);
    chk("rst_in_ready", 32'(irdy[0]), 1);
    chk("rst_w1_out_valid", 32'(ov[3]), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned max with a tie: the first 9 wins.
    expect_res(0, 8'd9, 1, 4);
    send(0, 8'd3, 1'b0);
    send(0, 8'd9, 1'b0);
    send(0, 8'd9, 1'b0);
    send(0, 8'd2, 1'b0);
    iv[0] = 1'b0;
    @(negedge clk);
    chk("latency_valid", 32'(ov[0]), 1);
    @(posedge clk);
    #1;
    idle(0, 2);

    // Same bytes, unsigned versus signed ordering.
    expect_res(0, 8'hF0, 0, 4);
    send(0, 8'hF0, 1'b0);
    send(0, 8'h05, 1'b0);
    send(0, 8'h80, 1'b0);
    send(0, 8'h7F, 1'b0);
    idle(0, 2);
    expect_res(1, 8'h7F, 3, 4);
    send(1, 8'hF0, 1'b0);
    send(1, 8'h05, 1'b0);
    send(1, 8'h80, 1'b0);
    send(1, 8'h7F, 1'b0);
    idle(1, 2);

    // Minimum with early close, then fresh windows.
    expect_res(2, 8'd4, 1, 3);
    send(2, 8'd7, 1'b0);
    send(2, 8'd4, 1'b0);
    send(2, 8'd4, 1'b1);
    expect_res(2, 8'd1, 2, 4);
    send(2, 8'd5, 1'b0);
    send(2, 8'd6, 1'b0);
    send(2, 8'd1, 1'b0);
    send(2, 8'd1, 1'b0);
    expect_res(2, 8'd9, 0, 1);
    send(2, 8'd9, 1'b1);
    idle(2, 2);

    // Backpressure: result held stable, then release while closing a new window.
    ordy[0] = 1'b0;
    expect_res(0, 8'd8, 3, 4);
    send(0, 8'd1, 1'b0);
    send(0, 8'd2, 1'b0);
    send(0, 8'd3, 1'b0);
    send(0, 8'd8, 1'b0);
    iv[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ov[0]), 1);
      chk("hold_data", 32'(od[0]), 8);
      chk("hold_idx", oi32[0], 3);
      chk("hold_count", oc32[0], 4);
      chk("hold_in_ready", 32'(irdy[0]), 0);
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    expect_res(0, 8'd6, 0, 1);
    send(0, 8'd6, 1'b1);
    iv[0] = 1'b0;
    il[0] = 1'b0;
    @(negedge clk);
    chk("nogap_valid", 32'(ov[0]), 1);
    chk("nogap_data", 32'(od[0]), 6);
    @(posedge clk);
    #1;
    idle(0, 2);

    // Reset with a result pending: the result is discarded.
    ordy[0] = 1'b0;
    send(0, 8'd10, 1'b0);
    send(0, 8'd20, 1'b0);
    send(0, 8'd30, 1'b0);
    send(0, 8'd40, 1'b0);
    iv[0] = 1'b0;
    chk("pend_valid", 32'(ov[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("pend_rst_valid", 32'(ov[0]), 0);
    chk("pend_rst_data", 32'(od[0]), 0);
    chk("pend_rst_count", oc32[0], 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    ordy[0] = 1'b1;
    idle(0, 1);

    // Reset mid-window: the partial samples are discarded.
    send(0, 8'd200, 1'b0);
    send(0, 8'd250, 1'b0);
    iv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ov[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0, 1);
    expect_res(0, 8'd4, 3, 4);
    send(0, 8'd1, 1'b0);
    send(0, 8'd2, 1'b0);
    send(0, 8'd3, 1'b0);
    send(0, 8'd4, 1'b0);
    idle(0, 2);

    // Single-sample windows, back to back.
    begin
      logic [7:0] w1 [8];
      w1 = '{8'd5, 8'd1, 8'd255, 8'd0, 8'd77, 8'd77, 8'd128, 8'd3};
      for (int i = 0; i < 8; i++) begin
        expect_res(3, w1[i], 0, 1);
        send(3, w1[i], 1'b0);
      end
    end
    idle(3, 3);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
